// File: rtl/smi_flit_scale_stage_x2.sv
// rtl/smi_flit_scale_stage_x2.sv - SMI flit width expander, packs two input flits into one double-width output flit
//
// Ports:
//   clk          clock
//   srst         synchronous reset, active high
//   smiInReady   input flit valid
//   smiInEofc    input end-of-frame control (0 = more follows, N = final flit with N bytes)
//   smiInData    input flit data, FlitWidth bytes
//   smiInStop    input backpressure
//   smiOutReady  output flit valid
//   smiOutEofc   output end-of-frame control
//   smiOutData   output flit data, 2*FlitWidth bytes
//   smiOutStop   output backpressure
module smi_flit_scale_stage_x2 #(
    parameter int FlitWidth = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     smiInReady,
    input  logic [7:0]               smiInEofc,
    input  logic [FlitWidth*8-1:0]   smiInData,
    output logic                     smiInStop,
    output logic                     smiOutReady,
    output logic [7:0]               smiOutEofc,
    output logic [FlitWidth*16-1:0]  smiOutData,
    input  logic                     smiOutStop
);

    localparam int         W  = FlitWidth * 8;
    localparam logic [7:0] FW = 8'(FlitWidth);

    logic           low_valid_q, low_valid_d;
    logic [W-1:0]   low_reg_q,   low_reg_d;
    logic           out_valid_q, out_valid_d;
    logic [7:0]     out_eofc_q,  out_eofc_d;
    logic [2*W-1:0] out_data_q,  out_data_d;

    logic       in_accept;
    logic       out_pop;
    logic [7:0] eofc_clamped;

    // Input is only held off when the output register is full and cannot
    // drain this cycle, so an accepted flit always has somewhere to go.
    assign smiInStop = out_valid_q & smiOutStop;
    assign in_accept = smiInReady & ~smiInStop;
    assign out_pop   = out_valid_q & ~smiOutStop;

    assign eofc_clamped = (smiInEofc > FW) ? FW : smiInEofc;

    always_comb begin
        low_valid_d = low_valid_q;
        low_reg_d   = low_reg_q;
        out_valid_d = out_valid_q & ~out_pop;
        out_eofc_d  = out_eofc_q;
        out_data_d  = out_data_q;

        if (in_accept) begin
            if (!low_valid_q) begin
                if (smiInEofc == 8'd0) begin
                    // First half of a pair: park it in the low lane.
                    low_reg_d   = smiInData;
                    low_valid_d = 1'b1;
                end else begin
                    // Final flit landing in the low lane: ship it alone.
                    out_data_d  = {{W{1'b0}}, smiInData};
                    out_eofc_d  = eofc_clamped;
                    out_valid_d = 1'b1;
                end
            end else begin
                // Second half completes the pair; a final flit here means the
                // whole low lane is valid plus N bytes of the high lane.
                out_data_d  = {smiInData, low_reg_q};
                out_eofc_d  = (smiInEofc == 8'd0) ? 8'd0 : eofc_clamped + FW;
                out_valid_d = 1'b1;
                low_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            low_valid_q <= 1'b0;
            low_reg_q   <= '0;
            out_valid_q <= 1'b0;
            out_eofc_q  <= 8'd0;
            out_data_q  <= '0;
        end else begin
            low_valid_q <= low_valid_d;
            low_reg_q   <= low_reg_d;
            out_valid_q <= out_valid_d;
            out_eofc_q  <= out_eofc_d;
            out_data_q  <= out_data_d;
        end
    end

    assign smiOutReady = out_valid_q;
    assign smiOutEofc  = out_eofc_q;
    assign smiOutData  = out_data_q;

endmodule

// File: tb/tb_smi_flit_scale_stage_x2.sv
// tb/tb_smi_flit_scale_stage_x2.sv - directed and randomized checks of smi_flit_scale_stage_x2
module tb_smi_flit_scale_stage_x2;

    logic        clk = 1'b0;
    logic        srst;
    logic        smiInReady;
    logic [7:0]  smiInEofc;
    logic [31:0] smiInData;
    logic        smiInStop;
    logic        smiOutReady;
    logic [7:0]  smiOutEofc;
    logic [63:0] smiOutData;
    logic        smiOutStop;

    int n_assert = 0;
    int n_fail   = 0;

    smi_flit_scale_stage_x2 #(.FlitWidth(4)) dut (
        .clk         (clk),
        .srst        (srst),
        .smiInReady  (smiInReady),
        .smiInEofc   (smiInEofc),
        .smiInData   (smiInData),
        .smiInStop   (smiInStop),
        .smiOutReady (smiOutReady),
        .smiOutEofc  (smiOutEofc),
        .smiOutData  (smiOutData),
        .smiOutStop  (smiOutStop)
    );

    always #5 clk = ~clk;

    logic        m_low_valid = 1'b0;
    logic [31:0] m_low       = '0;
    logic [71:0] exp_q[$];
    logic [71:0] obs_q[$];
    logic        mon_en = 1'b0;

    always @(negedge clk)
        if (mon_en && smiOutReady && !smiOutStop)
            obs_q.push_back({smiOutEofc, smiOutData});

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model_push(input logic [31:0] d, input logic [7:0] e);
        logic [7:0] n;
        n = (e > 8'd4) ? 8'd4 : e;
        if (!m_low_valid) begin
            if (e == 8'd0) begin
                m_low       = d;
                m_low_valid = 1'b1;
            end else begin
                exp_q.push_back({n, 32'h0, d});
            end
        end else begin
            exp_q.push_back({(e == 8'd0) ? 8'd0 : n + 8'd4, d, m_low});
            m_low_valid = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic [7:0] e, input logic [31:0] d);
        smiInReady = rdy;
        smiInEofc  = e;
        smiInData  = d;
    endtask

    initial begin
        int          stalls;
        int          cyc;
        int          len;
        logic        done;
        logic [31:0] d;
        logic [7:0]  e;

        srst = 1'b1;
        smiOutStop = 1'b0;
        drive(1'b0, 8'd0, 32'h0);
        tick();
        tick();
        check("reset_out_ready", smiOutReady, 1'b0);
        check("reset_out_eofc", smiOutEofc, 8'd0);
        check("reset_out_data", smiOutData, 64'h0);
        check("reset_in_stop", smiInStop, 1'b0);
        srst = 1'b0;

        drive(1'b1, 8'd0, 32'h03020100);
        tick();
        check("pair_first_no_out", smiOutReady, 1'b0);
        drive(1'b1, 8'd4, 32'h07060504);
        tick();
        check("pair_out_ready", smiOutReady, 1'b1);
        check("pair_out_data", smiOutData, 64'h0706050403020100);
        check("pair_out_eofc", smiOutEofc, 8'd8);
        drive(1'b0, 8'd0, 32'h0);
        tick();
        check("pair_popped", smiOutReady, 1'b0);

        drive(1'b1, 8'd0, 32'h11111111);
        tick();
        drive(1'b1, 8'd0, 32'h22222222);
        tick();
        check("f3_out1_data", smiOutData, 64'h2222222211111111);
        check("f3_out1_eofc", smiOutEofc, 8'd0);
        drive(1'b1, 8'd2, 32'h00003333);
        tick();
        check("f3_out2_ready", smiOutReady, 1'b1);
        check("f3_out2_data", smiOutData, 64'h0000000000003333);
        check("f3_out2_eofc", smiOutEofc, 8'd2);
        drive(1'b0, 8'd0, 32'h0);
        tick();

        smiOutStop = 1'b1;
        drive(1'b1, 8'd4, 32'hAABBCCDD);
        tick();
        drive(1'b1, 8'd1, 32'h00000055);
        for (int i = 0; i < 5; i++) begin
            check("stall_in_stop", smiInStop, 1'b1);
            check("stall_out_ready", smiOutReady, 1'b1);
            check("stall_out_data", smiOutData, 64'h00000000AABBCCDD);
            check("stall_out_eofc", smiOutEofc, 8'd4);
            tick();
        end
        smiOutStop = 1'b0;
        #1;
        check("release_in_stop", smiInStop, 1'b0);
        tick();
        check("release_out_data", smiOutData, 64'h0000000000000055);
        check("release_out_eofc", smiOutEofc, 8'd1);
        check("release_out_ready", smiOutReady, 1'b1);
        drive(1'b0, 8'd0, 32'h0);
        tick();
        check("release_drained", smiOutReady, 1'b0);

        drive(1'b1, 8'd0, 32'hA0A0A0A0);
        tick();
        drive(1'b1, 8'd3, 32'h00B1B2B3);
        tick();
        check("hi_end_data", smiOutData, 64'h00B1B2B3A0A0A0A0);
        check("hi_end_eofc", smiOutEofc, 8'd7);
        drive(1'b1, 8'd1, 32'h000000D1);
        tick();
        check("single_data", smiOutData, 64'h00000000000000D1);
        check("single_eofc", smiOutEofc, 8'd1);
        drive(1'b1, 8'd9, 32'hE1E2E3E4);
        tick();
        check("clamp_data", smiOutData, 64'h00000000E1E2E3E4);
        check("clamp_eofc", smiOutEofc, 8'd4);
        drive(1'b1, 8'd0, 32'hC0C0C0C0);
        tick();
        drive(1'b1, 8'd200, 32'hC1C1C1C1);
        tick();
        check("clamp_hi_eofc", smiOutEofc, 8'd8);
        drive(1'b0, 8'd0, 32'h0);
        tick();

        drive(1'b1, 8'd0, 32'hDEADBEEF);
        tick();
        srst = 1'b1;
        drive(1'b1, 8'd1, 32'h0000005A);
        tick();
        srst = 1'b0;
        check("rst_low_out_ready", smiOutReady, 1'b0);
        check("rst_low_out_data", smiOutData, 64'h0);
        drive(1'b1, 8'd2, 32'h00001234);
        tick();
        check("rst_low_realign_data", smiOutData, 64'h0000000000001234);
        check("rst_low_realign_eofc", smiOutEofc, 8'd2);

        smiOutStop = 1'b1;
        drive(1'b1, 8'd4, 32'h44444444);
        tick();
        tick();
        check("rst_out_pre_ready", smiOutReady, 1'b1);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        check("rst_out_ready", smiOutReady, 1'b0);
        check("rst_out_eofc", smiOutEofc, 8'd0);
        check("rst_out_data", smiOutData, 64'h0);
        check("rst_out_in_stop", smiInStop, 1'b0);
        smiOutStop = 1'b0;
        drive(1'b0, 8'd0, 32'h0);
        tick();

        mon_en = 1'b1;
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            d = 32'h100 + 32'(i);
            e = (i == 15) ? 8'd4 : 8'd0;
            model_push(d, e);
            drive(1'b1, e, d);
            @(negedge clk);
            if (smiInStop) stalls++;
            tick();
        end
        drive(1'b0, 8'd0, 32'h0);
        tick();
        check("rate_stalls", stalls, 0);
        check("rate_out_count", obs_q.size(), 8);

        cyc = 0;
        for (int f = 0; f < 25; f++) begin
            len = $urandom_range(1, 40);
            for (int k = 0; k < len; k++) begin
                d = $urandom;
                e = (k == len - 1) ? 8'($urandom_range(1, 9)) : 8'd0;
                model_push(d, e);
                smiInEofc = e;
                smiInData = d;
                done = 1'b0;
                while (!done && cyc < 30000) begin
                    smiInReady = ($urandom_range(0, 3) != 0);
                    smiOutStop = ($urandom_range(0, 2) == 0);
                    @(negedge clk);
                    if (smiInReady && !smiInStop) done = 1'b1;
                    tick();
                    cyc++;
                end
            end
        end
        drive(1'b0, 8'd0, 32'h0);
        smiOutStop = 1'b0;
        repeat (5) tick();
        mon_en = 1'b0;
        check("rand_budget", (cyc < 30000), 1'b1);
        check("rand_out_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check("rand_out_flit", obs_q[i], exp_q[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
